// File: rtl/riscv_ahb_pkg.sv
// Shared AHB-Lite encodings, error-sequence state type and the access alignment check
// for the RISC-V AHB master bridge.
package riscv_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HALF  = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;
  localparam logic [2:0] HSIZE_DWORD = 3'b011;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  typedef enum logic {
    ERR_OK   = 1'b0,
    ERR_ERR1 = 1'b1
  } err_state_e;

  // Sizes wider than the bus are reported as misaligned as well.
  function automatic logic is_aligned(input logic [2:0] addr_lo,
                                      input logic [2:0] size,
                                      input logic [2:0] max_size);
    logic ok;
    ok = 1'b0;
    if (size <= max_size) begin
      case (size)
        HSIZE_BYTE:  ok = 1'b1;
        HSIZE_HALF:  ok = (addr_lo[0] == 1'b0);
        HSIZE_WORD:  ok = (addr_lo[1:0] == 2'b00);
        HSIZE_DWORD: ok = (addr_lo == 3'b000);
        default:     ok = 1'b0;
      endcase
    end else begin
      ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/riscv_sync_fifo.sv
// Synchronous FIFO used as the bridge request queue; flush discards all queued entries.
module riscv_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer update; the extra MSB distinguishes full from empty.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i && !full_o) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i && !empty_o) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage write
  always_ff @(posedge CLK) begin
    if (push_i && !full_o && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/riscv_ahb_master_bridge.sv
// AHB-Lite master bridge: queued core requests issued as pipelined SINGLE transfers,
// in-order responses, two-cycle HRESP error handling with address-phase retry.
module riscv_ahb_master_bridge
  import riscv_ahb_pkg::*;
#(
  parameter int         ADDR_W    = 32,
  parameter int         DATA_W    = 32,
  parameter int         DEPTH     = 2,
  parameter logic [3:0] HPROT_VAL = 4'b0011
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_write,
  input  logic [2:0]        req_size,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              flush,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic              HMASTLOCK,
  output logic [3:0]        HPROT,
  output logic [DATA_W-1:0] HWDATA,
  input  logic [DATA_W-1:0] HRDATA,
  input  logic              HREADY,
  input  logic              HRESP
);

  localparam int         ENT_W    = ADDR_W + 1 + 3 + DATA_W;
  localparam logic [2:0] MAX_SIZE = (DATA_W == 64) ? HSIZE_DWORD : HSIZE_WORD;

  logic              fifo_full_s, fifo_empty_s, push_s, pop_s, adv_s, load_a_s;
  logic [ENT_W-1:0]  fifo_rdata_s;
  logic [ADDR_W-1:0] h_addr_s;
  logic              h_write_s;
  logic [2:0]        h_size_s;
  logic [DATA_W-1:0] h_wdata_s;

  logic              a_valid_q, a_err_q, a_write_q;
  logic [ADDR_W-1:0] a_addr_q;
  logic [2:0]        a_size_q;
  logic [DATA_W-1:0] a_wdata_q;
  logic              d_valid_q, d_err_q, d_write_q;
  logic [DATA_W-1:0] d_wdata_q;
  err_state_e        st_q;
  logic              rsp_valid_q, rsp_err_q;
  logic [DATA_W-1:0] rsp_rdata_q;

  assign req_ready = !fifo_full_s && !flush;
  assign push_s    = req_valid && req_ready;
  // In ERR1 the address stage must not advance: its phase was cancelled and is retried.
  assign adv_s     = HREADY && (st_q == ERR_OK);
  assign load_a_s  = !a_valid_q || adv_s;
  assign pop_s     = !fifo_empty_s && load_a_s && !flush;

  assign {h_addr_s, h_write_s, h_size_s, h_wdata_s} = fifo_rdata_s;

  riscv_sync_fifo #(.WIDTH(ENT_W), .DEPTH(DEPTH)) u_req_fifo (
    .CLK     (CLK),
    .RST     (RST),
    .push_i  (push_s),
    .wdata_i ({req_addr, req_write, req_size, req_wdata}),
    .pop_i   (pop_s),
    .flush_i (flush),
    .rdata_o (fifo_rdata_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  // Address stage: loaded from the queue head, held while the bus stalls.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      a_valid_q <= 1'b0;
      a_err_q   <= 1'b0;
      a_addr_q  <= '0;
      a_write_q <= 1'b0;
      a_size_q  <= 3'b000;
      a_wdata_q <= '0;
    end else if (pop_s) begin
      a_valid_q <= 1'b1;
      a_err_q   <= !is_aligned(h_addr_s[2:0], h_size_s, MAX_SIZE);
      a_addr_q  <= h_addr_s;
      a_write_q <= h_write_s;
      a_size_q  <= h_size_s;
      a_wdata_q <= h_wdata_s;
    end else if (adv_s) begin
      a_valid_q <= 1'b0;
    end
  end

  // Data stage, error FSM and registered response.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      d_valid_q   <= 1'b0;
      d_err_q     <= 1'b0;
      d_write_q   <= 1'b0;
      d_wdata_q   <= '0;
      st_q        <= ERR_OK;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      if (d_valid_q && HREADY) begin
        rsp_valid_q <= 1'b1;
        rsp_err_q   <= d_err_q || HRESP || (st_q == ERR_ERR1);
        if (!d_write_q && !d_err_q && !HRESP && (st_q == ERR_OK)) rsp_rdata_q <= HRDATA;
      end
      case (st_q)
        ERR_OK:   if (d_valid_q && !d_err_q && HRESP && !HREADY) st_q <= ERR_ERR1;
        ERR_ERR1: if (HREADY) st_q <= ERR_OK;
        default:  st_q <= ERR_OK;
      endcase
      if (adv_s) begin
        d_valid_q <= a_valid_q;
        d_err_q   <= a_err_q;
        d_write_q <= a_write_q;
        d_wdata_q <= a_wdata_q;
      end else if (HREADY) begin
        d_valid_q <= 1'b0;
      end
    end
  end

  assign HTRANS    = (a_valid_q && !a_err_q && (st_q == ERR_OK)) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HADDR     = a_addr_q;
  assign HWRITE    = a_write_q;
  assign HSIZE     = a_size_q;
  assign HWDATA    = (d_valid_q && d_write_q && !d_err_q) ? d_wdata_q : '0;
  assign HBURST    = HBURST_SINGLE;
  assign HMASTLOCK = 1'b0;
  assign HPROT     = HPROT_VAL;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule
